// File: rtl/limb_sequencer.sv
// Multicycle control unit for the LIMB 8-bit CPU: fetch/decode/execute FSM,
// PC, data stack pointer and a hardware return-address stack.
//
// state   | meaning
// FETCH   | latch rom_data into IR when run = 1, no strobes
// EXEC    | decode IR, fire the single action of the opcode class
// MEM     | second half of POP: RAM read into rd at the incremented sp
// FAULT   | sticky error stop, left only through reset
module limb_sequencer #(
    parameter int         RS_DEPTH = 16,
    parameter logic [7:0] SP_RESET = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [7:0]  pc,
    input  logic [31:0] rom_data,
    output logic [31:0] ir,
    output logic [3:0]  rf_src_a,
    output logic [3:0]  rf_src_b,
    output logic [3:0]  rf_dst,
    output logic        rf_we,
    output logic        rf_wsel,
    output logic [3:0]  alu_op,
    output logic        alu_b_imm,
    output logic [7:0]  imm,
    input  logic [5:0]  cmp_flags,
    input  logic [7:0]  rf_out_a,
    input  logic [7:0]  rf_out_b,
    output logic [7:0]  ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    output logic [7:0]  sp,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        retired
);

    localparam int RS_AW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam logic [RS_AW:0] RS_FULL = (RS_AW + 1)'(RS_DEPTH);
    localparam logic [RS_AW:0] RS_ONE  = (RS_AW + 1)'(1);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_FAULT} state_t;

    state_t         state_q, state_d;
    logic [7:0]     pc_q, pc_d;
    logic [7:0]     sp_q, sp_d;
    logic [31:0]    ir_q, ir_d;
    logic           fault_q, fault_d;
    logic [1:0]     code_q, code_d;
    logic [RS_AW:0] rs_cnt_q, rs_cnt_d;
    logic [7:0]     rs_mem_q [RS_DEPTH];

    logic [7:0]       op;
    logic [3:0]       rd, rs1, rs2;
    logic [7:0]       pc_inc;
    logic [RS_AW-1:0] rs_wr_idx, rs_top_idx;
    logic             rs_push, rs_full, rs_empty;
    logic             cond;
    logic [3:0]       alu_sel;
    logic [1:0]       fault_req;
    logic             rf_we_raw, ram_we_raw, retired_raw;

    assign op         = ir_q[31:24];
    assign rd         = ir_q[23:20];
    assign rs1        = ir_q[19:16];
    assign rs2        = ir_q[11:8];
    assign imm        = ir_q[7:0];
    assign pc_inc     = pc_q + 8'd1;
    assign rs_wr_idx  = rs_cnt_q[RS_AW-1:0];
    assign rs_top_idx = rs_cnt_q[RS_AW-1:0] - RS_AW'(1);
    assign rs_full    = (rs_cnt_q == RS_FULL);
    assign rs_empty   = (rs_cnt_q == '0);

    // Branch and call families share the condition encoding in op[2:0].
    always_comb begin
        case (op[2:0])
            3'd0:    cond = cmp_flags[5];
            3'd1:    cond = cmp_flags[4];
            3'd2:    cond = cmp_flags[3];
            3'd3:    cond = cmp_flags[2];
            3'd4:    cond = cmp_flags[1];
            3'd5:    cond = cmp_flags[0];
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        case (op[2:0])
            3'd4:    alu_sel = 4'd7;
            3'd6:    alu_sel = 4'd4;
            default: alu_sel = {1'b0, op[2:0]};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        sp_d        = sp_q;
        ir_d        = ir_q;
        fault_d     = fault_q;
        code_d      = code_q;
        rs_cnt_d    = rs_cnt_q;
        rs_push     = 1'b0;
        fault_req   = 2'd0;
        rf_src_a    = rs1;
        rf_src_b    = rs2;
        rf_dst      = rd;
        rf_we_raw   = 1'b0;
        rf_wsel     = 1'b0;
        alu_op      = 4'd0;
        alu_b_imm   = 1'b0;
        ram_addr    = rf_out_a;
        ram_wdata   = rf_out_b;
        ram_we_raw  = 1'b0;
        retired_raw = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (run) begin
                    ir_d    = rom_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_d        = pc_inc;
                state_d     = S_FETCH;
                retired_raw = 1'b1;
                case (op)
                    8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6,
                    8'hC8, 8'hC9, 8'hCA, 8'hCB, 8'hCC: begin
                        alu_op    = alu_sel;
                        alu_b_imm = op[3];
                        rf_we_raw = 1'b1;
                    end
                    8'h80: begin
                        rf_src_a  = 4'd15;
                        rf_we_raw = 1'b1;
                        rf_wsel   = 1'b1;
                    end
                    8'h81, 8'h82: begin
                        rf_src_a   = 4'd15;
                        rf_src_b   = rs1;
                        ram_wdata  = op[1] ? imm : rf_out_b;
                        ram_we_raw = 1'b1;
                    end
                    8'h40, 8'h41: begin
                        rf_src_b   = rs1;
                        ram_addr   = sp_q;
                        ram_wdata  = op[0] ? imm : rf_out_b;
                        ram_we_raw = 1'b1;
                        sp_d       = sp_q - 8'd1;
                    end
                    8'h42: begin
                        sp_d        = sp_q + 8'd1;
                        pc_d        = pc_q;
                        state_d     = S_MEM;
                        retired_raw = 1'b0;
                    end
                    8'h43: pc_d = imm;
                    8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5: begin
                        alu_op = 4'd1;
                        if (cond) pc_d = imm;
                    end
                    8'hD8, 8'hD9, 8'hDA, 8'hDB, 8'hDC, 8'hDD, 8'h44: begin
                        alu_op = 4'd1;
                        if (op == 8'h44 || cond) begin
                            if (rs_full) begin
                                fault_req = 2'd2;
                            end else begin
                                rs_push  = 1'b1;
                                rs_cnt_d = rs_cnt_q + RS_ONE;
                                pc_d     = imm;
                            end
                        end
                    end
                    8'h00: begin
                        if (rs_empty) begin
                            fault_req = 2'd3;
                        end else begin
                            pc_d     = rs_mem_q[rs_top_idx];
                            rs_cnt_d = rs_cnt_q - RS_ONE;
                        end
                    end
                    default: fault_req = 2'd1;
                endcase
                // A faulting instruction leaves no architectural trace.
                if (fault_req != 2'd0) begin
                    pc_d        = pc_q;
                    sp_d        = sp_q;
                    rs_cnt_d    = rs_cnt_q;
                    rs_push     = 1'b0;
                    rf_we_raw   = 1'b0;
                    ram_we_raw  = 1'b0;
                    retired_raw = 1'b0;
                    fault_d     = 1'b1;
                    code_d      = fault_req;
                    state_d     = S_FAULT;
                end
            end
            S_MEM: begin
                ram_addr    = sp_q;
                rf_we_raw   = 1'b1;
                rf_wsel     = 1'b1;
                pc_d        = pc_inc;
                retired_raw = 1'b1;
                state_d     = S_FETCH;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: state_d = S_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            pc_q     <= 8'd0;
            sp_q     <= SP_RESET;
            ir_q     <= 32'd0;
            fault_q  <= 1'b0;
            code_q   <= 2'd0;
            rs_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            sp_q     <= sp_d;
            ir_q     <= ir_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
            rs_cnt_q <= rs_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && rs_push) begin
            rs_mem_q[rs_wr_idx] <= pc_inc;
        end
    end

    // Strobes must drop the moment reset asserts, even mid-instruction.
    assign rf_we      = rf_we_raw & reset;
    assign ram_we     = ram_we_raw & reset;
    assign retired    = retired_raw & reset;
    assign pc         = pc_q;
    assign sp         = sp_q;
    assign ir         = ir_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule
